// File: rtl/power_pkg.sv
// power_pkg -- shared types and constants for the power_unit slice.
//
// Contents:
//   IN_W, EXP_W, OUT_W  widths of base X, exponent N and result
//   PROD_W              width of the full acc*X product
//   SAT_MAX             saturation value loaded when a product overflows
//                       (used only when POWER_UNIT_OVF_EN is defined)
//   state_t             controller states IDLE / CALC / DONE
package power_pkg;

    localparam int IN_W   = 10;
    localparam int EXP_W  = 3;
    localparam int OUT_W  = 20;
    localparam int PROD_W = OUT_W + IN_W;

    localparam logic [OUT_W-1:0] SAT_MAX = 20'hFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/power_mul.sv
// power_mul -- combinational 20x10 unsigned multiply step for power_unit.
//
// Build option: POWER_UNIT_OVF_EN selects saturation to SAT_MAX on overflow;
// without it the product wraps modulo 2^OUT_W.
//
// Ports:
//   a    [OUT_W-1:0]  in   running accumulator
//   b    [IN_W-1:0]   in   base X
//   p    [OUT_W-1:0]  out  next accumulator (saturated or truncated)
//   ovf               out  full product does not fit in OUT_W bits
module power_mul
    import power_pkg::*;
(
    input  logic [OUT_W-1:0] a,
    input  logic [IN_W-1:0]  b,
    output logic [OUT_W-1:0] p,
    output logic             ovf
);

    logic [PROD_W-1:0] full;

    assign full = PROD_W'(a) * PROD_W'(b);
    assign ovf  = |full[PROD_W-1:OUT_W];

`ifdef POWER_UNIT_OVF_EN
    assign p = ovf ? SAT_MAX : full[OUT_W-1:0];
`else
    assign p = full[OUT_W-1:0];
`endif

endmodule

// File: rtl/power_unit.sv
// power_unit -- sequential X^N engine, one multiply per cycle.
//
// A request in IDLE captures X and N; the unit then spends N cycles in CALC
// multiplying the accumulator by X and one cycle in DONE presenting the
// result, so out_valid rises N+1 cycles after in_valid. Requests arriving
// while busy (including the DONE cycle) are dropped.
//
// Build option: POWER_UNIT_OVF_EN enables saturation and the out_ovf port.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   one-cycle request strobe
//   in_data_1  in   base X (unsigned, IN_W bits)
//   in_data_2  in   exponent N (unsigned, EXP_W bits)
//   busy       out  state is not IDLE
//   out_valid  out  one-cycle result strobe (DONE state)
//   out_data   out  result X^N, held until the next DONE
//   out_ovf    out  result saturated (only with POWER_UNIT_OVF_EN)
module power_unit
    import power_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data_1,
    input  logic [EXP_W-1:0] in_data_2,
    output logic             busy,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data
`ifdef POWER_UNIT_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    state_t           state;
    state_t           state_next;
    logic [IN_W-1:0]  x;
    logic [OUT_W-1:0] acc;
    logic [EXP_W-1:0] cnt;
    logic [OUT_W-1:0] mul_p;
    logic             mul_ovf;
    logic             last_step;

    power_mul u_mul (
        .a   (acc),
        .b   (x),
        .p   (mul_p),
        .ovf (mul_ovf)
    );

    assign last_step = (cnt == EXP_W'(1));
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (in_valid) state_next = (in_data_2 == '0) ? DONE : CALC;
            CALC: if (last_step) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

`ifdef POWER_UNIT_OVF_EN
    logic ovf;
    logic ovf_next;

    // Sticky: once any step saturates, the whole result is flagged.
    assign ovf_next = ovf | mul_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf     <= 1'b0;
            out_ovf <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    ovf <= 1'b0;
                    if (in_data_2 == '0) out_ovf <= 1'b0;
                end
                CALC: begin
                    ovf <= ovf_next;
                    if (last_step) out_ovf <= ovf_next;
                end
                default: ;
            endcase
        end
    end
`else
    logic ovf_unused;
    assign ovf_unused = mul_ovf;
`endif

    // out_data is loaded on the edge that enters DONE, so it is already
    // valid during the DONE cycle and simply holds afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            x        <= '0;
            acc      <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    x   <= in_data_1;
                    acc <= OUT_W'(1);
                    cnt <= in_data_2;
                    if (in_data_2 == '0) out_data <= OUT_W'(1);
                end
                CALC: begin
                    acc <= mul_p;
                    cnt <= cnt - 1'b1;
                    if (last_step) out_data <= mul_p;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_power_unit.sv
// tb_power_unit -- directed self-checking bench for power_unit.
// Inputs change 1 time unit after the rising edge; outputs are recorded on
// the falling edge. Cycle T is the cycle whose closing edge samples in_valid.
module tb_power_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [9:0]  in_data_1;
    logic [2:0]  in_data_2;
    logic        busy;
    logic        out_valid;
    logic [19:0] out_data;
`ifdef POWER_UNIT_OVF_EN
    logic        out_ovf;
`endif

    power_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data_1 (in_data_1),
        .in_data_2 (in_data_2),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data)
`ifdef POWER_UNIT_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // Result monitor
    int          pulses = 0;
    int          pulse_cyc = 0;
    logic [19:0] pulse_data = '0;
    logic        pulse_ovf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            pulses     = pulses + 1;
            pulse_cyc  = cyc;
            pulse_data = out_data;
`ifdef POWER_UNIT_OVF_EN
            pulse_ovf  = out_ovf;
`endif
        end
    end

    typedef struct {
        logic [9:0]  x;
        logic [2:0]  n;
        logic [19:0] d;
        int          lat;
        logic        ovf;
    } vec_t;

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [9:0] x, input logic [2:0] n, output int t);
        in_data_1 = x;
        in_data_2 = n;
        in_valid  = 1'b1;
        t         = cyc;
        step(1);
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data_1 = 10'd5;
        in_data_2 = 3'd0;
        step(3);
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 20'd0) begin n_mis++; $display("FAIL reset_out_data: got %h want 0", out_data); end
`ifdef POWER_UNIT_OVF_EN
        n_cmp++; if (out_ovf !== 1'b0) begin n_mis++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
`endif
        rst      = 1'b0;
        in_valid = 1'b0;
        step(3);
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_ignored_req_busy: got %b want 0", busy); end
        n_cmp++; if (pulses !== 0) begin n_mis++; $display("FAIL reset_ignored_req_pulses: got %0d want 0", pulses); end
    endtask

    task automatic test_vectors();
        vec_t vecs[7];
        int   t;
        vecs[0] = '{x: 10'd1023, n: 3'd2, d: 20'hFF801, lat: 3, ovf: 1'b0};
`ifdef POWER_UNIT_OVF_EN
        vecs[1] = '{x: 10'd1023, n: 3'd3, d: 20'hFFFFF, lat: 4, ovf: 1'b1};
`else
        vecs[1] = '{x: 10'd1023, n: 3'd3, d: 20'h00BFF, lat: 4, ovf: 1'b0};
`endif
        vecs[2] = '{x: 10'd3,    n: 3'd4, d: 20'd81,    lat: 5, ovf: 1'b0};
        vecs[3] = '{x: 10'd5,    n: 3'd0, d: 20'd1,     lat: 1, ovf: 1'b0};
        vecs[4] = '{x: 10'd0,    n: 3'd3, d: 20'd0,     lat: 4, ovf: 1'b0};
        vecs[5] = '{x: 10'd0,    n: 3'd0, d: 20'd1,     lat: 1, ovf: 1'b0};
        vecs[6] = '{x: 10'd7,    n: 3'd1, d: 20'd7,     lat: 2, ovf: 1'b0};
        for (int i = 0; i < 7; i++) begin
            pulses = 0;
            issue(vecs[i].x, vecs[i].n, t);
            n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL vec%0d_busy: got %b want 1", i, busy); end
            step(11);
            n_cmp++; if (pulses !== 1) begin n_mis++; $display("FAIL vec%0d_pulses: got %0d want 1", i, pulses); end
            n_cmp++; if (pulse_cyc - t !== vecs[i].lat) begin n_mis++; $display("FAIL vec%0d_latency: got %0d want %0d", i, pulse_cyc - t, vecs[i].lat); end
            n_cmp++; if (pulse_data !== vecs[i].d) begin n_mis++; $display("FAIL vec%0d_data: got %h want %h", i, pulse_data, vecs[i].d); end
`ifdef POWER_UNIT_OVF_EN
            n_cmp++; if (pulse_ovf !== vecs[i].ovf) begin n_mis++; $display("FAIL vec%0d_ovf: got %b want %b", i, pulse_ovf, vecs[i].ovf); end
`endif
            n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== vecs[i].d) begin
                n_mis++; $display("FAIL vec%0d_hold: got valid=%b busy=%b data=%h want 0 0 %h", i, out_valid, busy, out_data, vecs[i].d);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        pulses = 0;
        issue(10'd2, 3'd7, t);
        step(1);
        in_data_1 = 10'd9; in_data_2 = 3'd1; in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        step(5);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 20'd128) begin
            n_mis++; $display("FAIL b2b_done_cycle: got valid=%b data=%0d want 1 128", out_valid, out_data);
        end
        in_data_1 = 10'd9; in_data_2 = 3'd1; in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL b2b_done_req_ignored: got busy=%b want 0", busy); end
        step(6);
        n_cmp++; if (pulses !== 1) begin n_mis++; $display("FAIL b2b_pulses: got %0d want 1", pulses); end
        n_cmp++; if (pulse_cyc - t !== 8) begin n_mis++; $display("FAIL b2b_latency: got %0d want 8", pulse_cyc - t); end
        n_cmp++; if (pulse_data !== 20'd128) begin n_mis++; $display("FAIL b2b_data: got %0d want 128", pulse_data); end
    endtask

    task automatic test_abort();
        int t;
        pulses = 0;
        issue(10'd2, 3'd7, t);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (out_data !== 20'd0) begin n_mis++; $display("FAIL abort_out_data: got %h want 0", out_data); end
        step(10);
        n_cmp++; if (pulses !== 0) begin n_mis++; $display("FAIL abort_pulses: got %0d want 0", pulses); end
        issue(10'd4, 3'd2, t);
        step(11);
        n_cmp++; if (pulses !== 1) begin n_mis++; $display("FAIL abort_next_pulses: got %0d want 1", pulses); end
        n_cmp++; if (pulse_data !== 20'd16) begin n_mis++; $display("FAIL abort_next_data: got %0d want 16", pulse_data); end
        n_cmp++; if (pulse_cyc - t !== 3) begin n_mis++; $display("FAIL abort_next_latency: got %0d want 3", pulse_cyc - t); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data_1 = '0;
        in_data_2 = '0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
